// File: rtl/envelope_pkg.sv
// Shared types and arithmetic helpers for the envelope tracker family.
package envelope_pkg;

    // Widest operand the helpers accept; callers zero-extend into it.
    localparam int unsigned MAX_W = 32;

    typedef enum logic [1:0] {
        ACQ  = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    // a >= b + t evaluated one bit wider so the sum never wraps.
    function automatic logic ge_sum(input logic [MAX_W-1:0] a,
                                    input logic [MAX_W-1:0] b,
                                    input logic [MAX_W-1:0] t);
        return {1'b0, a} >= ({1'b0, b} + {1'b0, t});
    endfunction

    // Increment v, holding at 2^w-1 (w <= MAX_W).
    function automatic logic [MAX_W-1:0] sat_inc(input logic [MAX_W-1:0] v,
                                                 input int unsigned       w);
        logic [MAX_W:0] lim;
        lim = ((MAX_W+1)'(1) << w) - (MAX_W+1)'(1);
        if ({1'b0, v} >= lim) begin
            return v;
        end
        return v + MAX_W'(1);
    endfunction

endpackage

// File: rtl/envelope_stats.sv
// Registers amplitude and midpoint from a committed min/max pair.
module envelope_stats #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             update,
    input  logic [WIDTH-1:0] min,
    input  logic [WIDTH-1:0] max,
    output logic [WIDTH-1:0] amplitude,
    output logic [WIDTH-1:0] mid
);

    logic [WIDTH:0] sum;

    // Midpoint sum carried one bit wider so it cannot overflow.
    always_comb begin
        sum = {1'b0, max} + {1'b0, min};
    end

    // Latch derived values only when a new peak was committed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            amplitude <= '0;
            mid       <= '0;
        end else if (clear) begin
            amplitude <= '0;
            mid       <= '0;
        end else if (update) begin
            amplitude <= (max >= min) ? (max - min) : '0;
            mid       <= WIDTH'(sum >> 1);
        end
    end

endmodule

// File: rtl/envelope_tracker.sv
// Hysteretic envelope follower: commits low/high peaks, measures period, drops lock on inactivity.
module envelope_tracker
    import envelope_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PERIOD_W = 16,
    parameter int unsigned TIMEOUT  = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                sample_valid,
    input  logic [WIDTH-1:0]    adc_d,
    input  logic [WIDTH-1:0]    threshold,
    output logic [WIDTH-1:0]    min,
    output logic [WIDTH-1:0]    max,
    output logic [WIDTH-1:0]    amplitude,
    output logic [WIDTH-1:0]    mid,
    output logic                high_peak,
    output logic                low_peak,
    output logic [PERIOD_W-1:0] period,
    output logic                locked
);

    state_t               state;
    logic [WIDTH-1:0]     cur_min;
    logic [WIDTH-1:0]     cur_max;
    logic [PERIOD_W-1:0]  pcnt;
    logic [PERIOD_W-1:0]  idle;
    logic                 seen_hi;
    logic                 seen_lo;

    logic                 hi_cond;
    logic                 lo_cond;
    logic                 hi_commit;
    logic                 lo_commit;
    logic                 timeout_hit;
    logic [PERIOD_W-1:0]  pcnt_inc;
    logic [PERIOD_W-1:0]  idle_inc;

    // Peak-commit decisions; strict compares keep equal samples from committing at threshold 0.
    always_comb begin
        hi_cond     = (adc_d < cur_max) &&
                      ge_sum(MAX_W'(cur_max), MAX_W'(adc_d), MAX_W'(threshold));
        lo_cond     = (adc_d > cur_min) &&
                      ge_sum(MAX_W'(adc_d), MAX_W'(cur_min), MAX_W'(threshold));
        hi_commit   = hi_cond && ((state == ACQ) || (state == HIGH));
        lo_commit   = lo_cond && ((state == LOW) || ((state == ACQ) && !hi_cond));
        pcnt_inc    = PERIOD_W'(sat_inc(MAX_W'(pcnt), PERIOD_W));
        idle_inc    = PERIOD_W'(sat_inc(MAX_W'(idle), PERIOD_W));
        timeout_hit = (TIMEOUT != 0) && !hi_commit && !lo_commit &&
                      (idle_inc == PERIOD_W'(TIMEOUT));
    end

    // Tracker state machine, period/idle counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACQ;
            cur_min   <= '1;
            cur_max   <= '0;
            min       <= '1;
            max       <= '0;
            high_peak <= 1'b0;
            low_peak  <= 1'b0;
            period    <= '0;
            locked    <= 1'b0;
            pcnt      <= '0;
            idle      <= '0;
            seen_hi   <= 1'b0;
            seen_lo   <= 1'b0;
        end else if (clear) begin
            state     <= ACQ;
            cur_min   <= '1;
            cur_max   <= '0;
            min       <= '1;
            max       <= '0;
            high_peak <= 1'b0;
            low_peak  <= 1'b0;
            period    <= '0;
            locked    <= 1'b0;
            pcnt      <= '0;
            idle      <= '0;
            seen_hi   <= 1'b0;
            seen_lo   <= 1'b0;
        end else begin
            high_peak <= 1'b0;
            low_peak  <= 1'b0;
            if (sample_valid) begin
                if (hi_commit) begin
                    max       <= cur_max;
                    cur_min   <= adc_d;
                    high_peak <= 1'b1;
                    state     <= LOW;
                    seen_hi   <= 1'b1;
                    locked    <= seen_lo;
                    idle      <= '0;
                    pcnt      <= '0;
                    if (seen_hi) begin
                        period <= pcnt_inc;
                    end
                end else if (lo_commit) begin
                    min      <= cur_min;
                    cur_max  <= adc_d;
                    low_peak <= 1'b1;
                    state    <= HIGH;
                    seen_lo  <= 1'b1;
                    locked   <= seen_hi;
                    idle     <= '0;
                    pcnt     <= pcnt_inc;
                end else if (timeout_hit) begin
                    state   <= ACQ;
                    cur_min <= '1;
                    cur_max <= '0;
                    locked  <= 1'b0;
                    seen_hi <= 1'b0;
                    seen_lo <= 1'b0;
                    pcnt    <= '0;
                    idle    <= '0;
                end else begin
                    idle <= idle_inc;
                    pcnt <= pcnt_inc;
                    unique case (state)
                        ACQ: begin
                            if (adc_d >= cur_max) begin
                                cur_max <= adc_d;
                            end else if (adc_d <= cur_min) begin
                                cur_min <= adc_d;
                            end
                        end
                        HIGH: begin
                            if (adc_d >= cur_max) begin
                                cur_max <= adc_d;
                            end
                        end
                        LOW: begin
                            if (adc_d <= cur_min) begin
                                cur_min <= adc_d;
                            end
                        end
                        default: begin
                            state <= ACQ;
                        end
                    endcase
                end
            end
        end
    end

    envelope_stats #(
        .WIDTH(WIDTH)
    ) u_stats (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .update    (high_peak | low_peak),
        .min       (min),
        .max       (max),
        .amplitude (amplitude),
        .mid       (mid)
    );

endmodule
